// File: rtl/data_mem_arb_pkg.sv
// rtl/data_mem_arb_pkg.sv - shared types and default sizes for the data memory arbiter
package data_mem_arb_pkg;

    localparam int DEF_ADDR_W    = 64;
    localparam int DEF_DATA_W    = 64;
    localparam int DEF_MEM_DEPTH = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arbState_t;

    typedef struct packed {
        logic                  write;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } memReq_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with a one-bit last-grant pointer
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic lastGrant;

    // On contention the port that did not win last time goes first.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = lastGrant ? 2'b01 : 2'b10;
        end
    end

    // Reset points at port 1 so port 0 takes the first contended grant.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lastGrant <= 1'b1;
        end else if (update && (|req)) begin
            lastGrant <= grant[1];
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port arbiter sequencing data memory accesses through IDLE/ISSUE/RESP
// Optional DATA_MEM_ARB_RANGE_CHECK_EN blocks and flags accesses at or beyond MEM_DEPTH.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    arbState_t   state;
    memReq_t     curReq;
    memReq_t     inReq;
    logic        owner;
    logic [1:0]  grant;
    logic        canAccept;
    logic        accept;
    logic        inErr;
    logic        curErr;
    logic [DATA_W-1:0] issueData;

    // Ready is gated by reset so nothing is accepted while reset is held.
    assign canAccept  = reset_n && ((state == IDLE) || (state == RESP));
    assign accept     = canAccept && (req0_valid || req1_valid);
    assign req0_ready = canAccept && grant[0];
    assign req1_ready = canAccept && grant[1];

    rr_arbiter2 arbiter (
        .clock   (clock),
        .reset_n (reset_n),
        .req     ({req1_valid, req0_valid}),
        .update  (accept),
        .grant   (grant)
    );

    always_comb begin
        inReq = '{write: req0_write, addr: req0_addr, wdata: req0_wdata};
        if (grant[1]) begin
            inReq = '{write: req1_write, addr: req1_addr, wdata: req1_wdata};
        end
    end

    assign mem_addr  = curReq.addr;
    assign mem_wdata = curReq.wdata;
    assign issueData = (curReq.write || curErr) ? '0 : mem_rdata;

`ifdef DATA_MEM_ARB_RANGE_CHECK_EN
    assign inErr = (inReq.addr >= ADDR_W'(MEM_DEPTH));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            curErr   <= 1'b0;
            rsp0_err <= 1'b0;
            rsp1_err <= 1'b0;
        end else begin
            if (accept) begin
                curErr <= inErr;
            end
            if (state == ISSUE) begin
                if (owner) begin
                    rsp1_err <= curErr;
                end else begin
                    rsp0_err <= curErr;
                end
            end
        end
    end
`else
    assign inErr    = 1'b0;
    assign curErr   = 1'b0;
    assign rsp0_err = 1'b0;
    assign rsp1_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            curReq     <= '0;
            owner      <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        curReq    <= inReq;
                        owner     <= grant[1];
                        mem_read  <= !inReq.write && !inErr;
                        mem_write <= inReq.write && !inErr;
                        state     <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    state <= RESP;
                    if (owner) begin
                        rsp1_valid <= 1'b1;
                        rsp1_rdata <= issueData;
                    end else begin
                        rsp0_valid <= 1'b1;
                        rsp0_rdata <= issueData;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter against a cycle-count reference model
module tb_data_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int DEPTH = 64;

`ifdef DATA_MEM_ARB_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req0_valid, req0_write, req0_ready, rsp0_valid, rsp0_err;
    logic          req1_valid, req1_write, req1_ready, rsp1_valid, rsp1_err;
    logic [AW-1:0] req0_addr, req1_addr, mem_addr;
    logic [DW-1:0] req0_wdata, req1_wdata, rsp0_rdata, rsp1_rdata;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_read, mem_write;

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_write (req0_write),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp0_err   (rsp0_err),
        .req1_valid (req1_valid),
        .req1_write (req1_write),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .rsp1_err   (rsp1_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] oorPat(logic [63:0] a);
        return a ^ 64'hA5A5_0000_0000_0000;
    endfunction

    // Bench-side memory: combinational read, write on the rising edge.
    logic [63:0] tbMem [DEPTH];
    assign mem_rdata = (mem_addr < 64'(DEPTH)) ? tbMem[mem_addr[5:0]] : oorPat(mem_addr);
    always @(posedge clock) begin
        if (mem_write && mem_addr < 64'(DEPTH)) tbMem[mem_addr[5:0]] = mem_wdata;
    end

    // Reference model: an access accepted in cycle c strobes in c+1 and responds in c+2.
    typedef struct {
        bit          port;
        bit          write;
        logic [63:0] addr;
        logic [63:0] wdata;
    } txn_t;

    int          cyc = 0;
    int          lastAcc = -100;
    bit          lg = 1'b1;
    txn_t        cur;
    logic [63:0] curRes;
    bit          curErr;
    logic [63:0] expRd [2];
    bit          expEr [2];
    bit          accNow [2];
    logic [63:0] modelMem [DEPTH];

    task automatic modelCycle();
        bit v0, v1, canAcc, issue, resp, inRange, blocked;
        int win;
        v0 = req0_valid;
        v1 = req1_valid;
        canAcc = (cyc >= lastAcc + 2);
        win = (v0 && v1) ? (lg ? 0 : 1) : (v1 ? 1 : 0);
        accNow[0] = canAcc && (v0 || v1) && (win == 0);
        accNow[1] = canAcc && (v0 || v1) && (win == 1);
        chk("ready0", req0_ready, accNow[0]);
        chk("ready1", req1_ready, accNow[1]);

        issue = (cyc == lastAcc + 1);
        resp = (cyc == lastAcc + 2);
        inRange = (cur.addr < 64'(DEPTH));
        blocked = RC && !inRange;
        chk("mem_read", mem_read, issue && !cur.write && !blocked);
        chk("mem_write", mem_write, issue && cur.write && !blocked);
        if (issue) begin
            if (!blocked) chk("mem_addr", mem_addr, cur.addr);
            if (cur.write && !blocked) chk("mem_wdata", mem_wdata, cur.wdata);
            curErr = blocked;
            if (blocked || cur.write) curRes = 64'h0;
            else curRes = inRange ? modelMem[cur.addr[5:0]] : oorPat(cur.addr);
            if (cur.write && inRange) modelMem[cur.addr[5:0]] = cur.wdata;
        end
        if (resp) begin
            expRd[cur.port] = curRes;
            expEr[cur.port] = curErr;
        end
        chk("rsp0_valid", rsp0_valid, resp && !cur.port);
        chk("rsp1_valid", rsp1_valid, resp && cur.port);
        chk("rsp0_rdata", rsp0_rdata, expRd[0]);
        chk("rsp1_rdata", rsp1_rdata, expRd[1]);
        chk("rsp0_err", rsp0_err, expEr[0]);
        chk("rsp1_err", rsp1_err, expEr[1]);

        if (accNow[0] || accNow[1]) begin
            lastAcc = cyc;
            lg = accNow[1];
            cur.port = accNow[1];
            cur.write = accNow[1] ? req1_write : req0_write;
            cur.addr = accNow[1] ? req1_addr : req0_addr;
            cur.wdata = accNow[1] ? req1_wdata : req0_wdata;
        end
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
            chk("rst_mem_read", mem_read, 0);
            chk("rst_mem_write", mem_write, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_rsp0", {rsp0_valid, rsp0_err, rsp0_rdata != 0}, 0);
            chk("rst_rsp1", {rsp1_valid, rsp1_err, rsp1_rdata != 0}, 0);
            lastAcc = -100;
            lg = 1'b1;
            expRd = '{64'h0, 64'h0};
            expEr = '{1'b0, 1'b0};
            accNow = '{1'b0, 1'b0};
        end else begin
            modelCycle();
        end
        cyc++;
    end

    bit          drvV [2];
    bit          drvW [2];
    logic [63:0] drvA [2];
    logic [63:0] drvD [2];

    task automatic applyDrv();
        req0_valid = drvV[0]; req0_write = drvW[0]; req0_addr = drvA[0]; req0_wdata = drvD[0];
        req1_valid = drvV[1]; req1_write = drvW[1]; req1_addr = drvA[1]; req1_wdata = drvD[1];
    endtask

    task automatic setReq(int p, bit v, bit w, logic [63:0] a, logic [63:0] d);
        drvV[p] = v; drvW[p] = w; drvA[p] = a; drvD[p] = d;
        applyDrv();
        #1;
    endtask

    task automatic newReq(int p, bit inRangeOnly);
        int r;
        r = $urandom_range(0, 15);
        drvW[p] = $urandom_range(0, 1) == 1;
        if (!inRangeOnly && r == 0) drvA[p] = 64'(64 + $urandom_range(0, 7));
        else if (!inRangeOnly && r == 1) drvA[p] = {32'hFFFF_FFFF, $urandom};
        else drvA[p] = 64'($urandom_range(0, 63));
        drvD[p] = {$urandom, $urandom};
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int nGr;
        logic [63:0] prior;
        for (int i = 0; i < DEPTH; i++) begin
            tbMem[i] = {$urandom, $urandom};
            modelMem[i] = tbMem[i];
        end
        reset_n = 1'b1;
        setReq(0, 0, 0, 0, 0);
        setReq(1, 0, 0, 0, 0);
        reset_n = 1'b0;

        // Reset held with both ports requesting, then both valid together.
        setReq(0, 1, 0, 64'd1, 0);
        setReq(1, 1, 0, 64'd2, 0);
        repeat (3) step();
        chk("rst_hold_ready0", req0_ready, 0);
        chk("rst_hold_ready1", req1_ready, 0);
        reset_n = 1'b1;
        #1;
        chk("first_grant_p0", req0_ready, 1);
        chk("first_grant_not_p1", req1_ready, 0);
        step();
        setReq(0, 0, 0, 0, 0);
        chk("p1_wait_in_issue", req1_ready, 0);
        step();
        chk("p1_grant_in_resp", req1_ready, 1);
        chk("rsp0_at_n2", rsp0_valid, 1);
        step();
        setReq(1, 0, 0, 0, 0);
        step();
        chk("rsp1_at_n4", rsp1_valid, 1);
        step();
        step();

        // Port 0 write then read-back of address 5.
        setReq(0, 1, 1, 64'd5, 64'hDEAD);
        chk("wr_ready", req0_ready, 1);
        step();
        setReq(0, 1, 0, 64'd5, 0);
        chk("wr_strobe", mem_write, 1);
        chk("wr_addr", mem_addr, 64'd5);
        step();
        chk("wr_rsp_valid", rsp0_valid, 1);
        chk("wr_rsp_rdata", rsp0_rdata, 0);
        chk("rd_accept_in_resp", req0_ready, 1);
        step();
        setReq(0, 0, 0, 0, 0);
        step();
        chk("rd_rsp_valid", rsp0_valid, 1);
        chk("rd_rsp_rdata", rsp0_rdata, 64'hDEAD);
        step();

        // Both ports continuously valid: port 0 went last, so grants run 1,0,1,0...
        drvV[0] = 1; drvV[1] = 1;
        newReq(0, 1);
        newReq(1, 1);
        nGr = 0;
        for (int i = 0; i < 16; i++) begin
            applyDrv();
            #1;
            if (req0_ready || req1_ready) begin
                chk("alt_grant", req1_ready, (nGr % 2) == 0);
                nGr++;
            end
            step();
            for (int p = 0; p < 2; p++) if (accNow[p]) newReq(p, 1);
        end
        chk("eight_accesses", nGr, 8);
        setReq(0, 0, 0, 0, 0);
        setReq(1, 0, 0, 0, 0);
        repeat (3) step();

        // Out-of-range read from port 1.
        setReq(1, 1, 0, 64'd64, 0);
        step();
        setReq(1, 0, 0, 0, 0);
        chk("oor_mem_read", mem_read, RC ? 0 : 1);
        step();
        chk("oor_rsp_valid", rsp1_valid, 1);
        chk("oor_rsp_err", rsp1_err, RC);
        chk("oor_rsp_rdata", rsp1_rdata, RC ? 64'h0 : 64'hA5A5_0000_0000_0040);
        step();

        // Reset in the middle of a port 0 write to address 9.
        prior = tbMem[9];
        setReq(0, 1, 1, 64'd9, 64'h1234_5678);
        step();
        setReq(0, 0, 0, 0, 0);
        chk("mid_rst_strobe_before", mem_write, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_strobe_drops", mem_write, 0);
        repeat (2) step();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mid_rst_no_rsp", rsp0_valid, 0);
            step();
        end
        setReq(0, 1, 0, 64'd9, 0);
        step();
        setReq(0, 0, 0, 0, 0);
        step();
        chk("mid_rst_rd_valid", rsp0_valid, 1);
        chk("mid_rst_prior_data", rsp0_rdata, prior);
        step();

        // Randomized traffic on both ports.
        drvV[0] = 0; drvV[1] = 0;
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (accNow[p] || !drvV[p]) begin
                    drvV[p] = $urandom_range(0, 3) != 0;
                    newReq(p, 0);
                end
            end
            applyDrv();
            step();
        end
        setReq(0, 0, 0, 0, 0);
        setReq(1, 0, 0, 0, 0);
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
